dac_i2c_target: RTL and testbench

- I2C target (slave) that receives the 3-byte DAC write frame our I2C master sends: command byte `{reg[4:0], cmd[1:0], x}`, value high byte, value low byte.
- Holds two 16-bit channel registers and supports register read-back.
- Used as an in-FPGA DAC model for loopback and bring-up, and as the target end for a board-to-board link.
- Samples raw SCL/SDA with the system clock; drives SDA open-drain only.

---
 rtl/dac_i2c_target.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_dac_i2c_target.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_i2c_target.sv
// I2C target modelling a two-channel 16-bit DAC with register read-back.
// Define DAC_I2C_TARGET_GENERAL_CALL_EN to accept the general call address with reset byte 0x06.
module dac_i2c_target #(
   parameter logic [6:0] TARGET_ADDR = 7'h60,
   parameter int         FILTER_LEN  = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scl_i,
   input  logic        sda_i,
   output logic        sda_o,
   output logic [15:0] ch0_value,
   output logic [15:0] ch1_value,
   output logic        update,
   output logic        update_ch,
   output logic        busy
);

   localparam int CNT_W = $clog2(FILTER_LEN) + 1;
`ifdef DAC_I2C_TARGET_GENERAL_CALL_EN
   localparam bit GC_EN = 1'b1;
`else
   localparam bit GC_EN = 1'b0;
`endif

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_CMD, S_CMD_ACK, S_DHI, S_DHI_ACK,
      S_DLO, S_DLO_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT_STOP
   } state_t;

   logic [1:0] w_raw;
   logic [1:0] w_filt;
   assign w_raw = {sda_i, scl_i};

   // Bit 0 is SCL, bit 1 is SDA; a level change needs FILTER_LEN agreeing samples.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_in
         logic             r_s1;
         logic             r_s2;
         logic             r_f;
         logic [CNT_W-1:0] r_cnt;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_s1  <= 1'b1;
               r_s2  <= 1'b1;
               r_f   <= 1'b1;
               r_cnt <= '0;
            end else begin
               r_s1 <= w_raw[gi];
               r_s2 <= r_s1;
               if (r_s2 == r_f) begin
                  r_cnt <= '0;
               end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
                  r_f   <= r_s2;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
         end
         assign w_filt[gi] = r_f;
      end
   endgenerate

   logic w_scl;
   logic w_sda;
   logic r_scl_d;
   logic r_sda_d;
   logic w_scl_rise;
   logic w_scl_fall;
   logic w_start;
   logic w_stop;

   assign w_scl      = w_filt[0];
   assign w_sda      = w_filt[1];
   assign w_scl_rise = w_scl & ~r_scl_d;
   assign w_scl_fall = ~w_scl & r_scl_d;
   assign w_start    = r_scl_d & w_scl & r_sda_d & ~w_sda;
   assign w_stop     = r_scl_d & w_scl & ~r_sda_d & w_sda;

   state_t      r_state,     w_state_next;
   logic [3:0]  r_bit_cnt,   w_bit_cnt_next;
   logic [7:0]  r_shift,     w_shift_next;
   logic [7:0]  r_tx,        w_tx_next;
   logic [7:0]  r_hi,        w_hi_next;
   logic [15:0] r_snap,      w_snap_next;
   logic [15:0] r_ch0,       w_ch0_next;
   logic [15:0] r_ch1,       w_ch1_next;
   logic        r_ptr,       w_ptr_next;
   logic        r_rd,        w_rd_next;
   logic        r_rd_lo,     w_rd_lo_next;
   logic        r_cmd_rd,    w_cmd_rd_next;
   logic        r_gc,        w_gc_next;
   logic        r_gc_clr,    w_gc_clr_next;
   logic        r_update,    w_update_next;
   logic        r_update_ch, w_update_ch_next;
   logic        r_busy,      w_busy_next;
   logic        r_sda_o,     w_sda_o_next;
   logic [7:0]  w_rd_byte;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scl_d     <= 1'b1;
         r_sda_d     <= 1'b1;
         r_state     <= S_IDLE;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_tx        <= '0;
         r_hi        <= '0;
         r_snap      <= '0;
         r_ch0       <= '0;
         r_ch1       <= '0;
         r_ptr       <= 1'b0;
         r_rd        <= 1'b0;
         r_rd_lo     <= 1'b0;
         r_cmd_rd    <= 1'b0;
         r_gc        <= 1'b0;
         r_gc_clr    <= 1'b0;
         r_update    <= 1'b0;
         r_update_ch <= 1'b0;
         r_busy      <= 1'b0;
         r_sda_o     <= 1'b1;
      end else begin
         r_scl_d     <= w_scl;
         r_sda_d     <= w_sda;
         r_state     <= w_state_next;
         r_bit_cnt   <= w_bit_cnt_next;
         r_shift     <= w_shift_next;
         r_tx        <= w_tx_next;
         r_hi        <= w_hi_next;
         r_snap      <= w_snap_next;
         r_ch0       <= w_ch0_next;
         r_ch1       <= w_ch1_next;
         r_ptr       <= w_ptr_next;
         r_rd        <= w_rd_next;
         r_rd_lo     <= w_rd_lo_next;
         r_cmd_rd    <= w_cmd_rd_next;
         r_gc        <= w_gc_next;
         r_gc_clr    <= w_gc_clr_next;
         r_update    <= w_update_next;
         r_update_ch <= w_update_ch_next;
         r_busy      <= w_busy_next;
         r_sda_o     <= w_sda_o_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_bit_cnt_next   = r_bit_cnt;
      w_shift_next     = r_shift;
      w_tx_next        = r_tx;
      w_hi_next        = r_hi;
      w_snap_next      = r_snap;
      w_ch0_next       = r_ch0;
      w_ch1_next       = r_ch1;
      w_ptr_next       = r_ptr;
      w_rd_next        = r_rd;
      w_rd_lo_next     = r_rd_lo;
      w_cmd_rd_next    = r_cmd_rd;
      w_gc_next        = r_gc;
      w_gc_clr_next    = r_gc_clr;
      w_update_next    = 1'b0;
      w_update_ch_next = r_update_ch;
      w_busy_next      = r_busy;
      w_sda_o_next     = r_sda_o;
      w_rd_byte        = r_rd_lo ? r_snap[15:8] : r_snap[7:0];

      if (w_stop) begin
         w_state_next  = S_IDLE;
         w_sda_o_next  = 1'b1;
         w_busy_next   = 1'b0;
         w_gc_next     = 1'b0;
         w_gc_clr_next = 1'b0;
      end else if (w_start) begin
         w_state_next   = S_ADDR;
         w_bit_cnt_next = '0;
         w_sda_o_next   = 1'b1;
         w_gc_next      = 1'b0;
         w_gc_clr_next  = 1'b0;
      end else begin
         case (r_state)
            S_ADDR, S_CMD, S_DHI, S_DLO: begin
               if (w_scl_rise && r_bit_cnt < 4'd8) begin
                  w_shift_next   = {r_shift[6:0], w_sda};
                  w_bit_cnt_next = r_bit_cnt + 4'd1;
               end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                  // Byte complete: either start driving the ACK or give up on the frame.
                  w_state_next = S_WAIT_STOP;
                  if (r_state == S_ADDR) begin
                     if (r_shift[7:1] == TARGET_ADDR) begin
                        w_state_next = S_ADDR_ACK;
                        w_sda_o_next = 1'b0;
                        w_busy_next  = 1'b1;
                        w_rd_next    = r_shift[0];
                        w_gc_next    = 1'b0;
                        w_snap_next  = r_ptr ? r_ch1 : r_ch0;
                     end else if (GC_EN && r_shift == 8'h00) begin
                        w_state_next = S_ADDR_ACK;
                        w_sda_o_next = 1'b0;
                        w_busy_next  = 1'b1;
                        w_rd_next    = 1'b0;
                        w_gc_next    = 1'b1;
                     end
                  end else if (r_state == S_CMD) begin
                     if (r_gc) begin
                        if (r_shift == 8'h06) begin
                           w_state_next  = S_CMD_ACK;
                           w_sda_o_next  = 1'b0;
                           w_gc_clr_next = 1'b1;
                        end
                     end else if (r_shift[7:3] <= 5'd1 && r_shift[2] == r_shift[1]) begin
                        w_state_next  = S_CMD_ACK;
                        w_sda_o_next  = 1'b0;
                        w_ptr_next    = r_shift[3];
                        w_cmd_rd_next = r_shift[2];
                     end
                  end else if (r_state == S_DHI) begin
                     w_state_next = S_DHI_ACK;
                     w_sda_o_next = 1'b0;
                     w_hi_next    = r_shift;
                  end else begin
                     w_state_next = S_DLO_ACK;
                     w_sda_o_next = 1'b0;
                  end
               end
            end
            S_ADDR_ACK, S_CMD_ACK, S_DHI_ACK, S_DLO_ACK: begin
               if (w_scl_rise && r_bit_cnt == 4'd8) begin
                  w_bit_cnt_next = 4'd9;
                  if (r_state == S_DLO_ACK) begin
                     if (r_ptr) w_ch1_next = {r_hi, r_shift};
                     else       w_ch0_next = {r_hi, r_shift};
                     w_update_next    = 1'b1;
                     w_update_ch_next = r_ptr;
                  end else if (r_state == S_CMD_ACK && r_gc_clr) begin
                     w_ch0_next       = '0;
                     w_ch1_next       = '0;
                     w_update_next    = 1'b1;
                     w_update_ch_next = 1'b0;
                     w_gc_clr_next    = 1'b0;
                  end
               end else if (w_scl_fall && r_bit_cnt == 4'd9) begin
                  w_bit_cnt_next = '0;
                  w_sda_o_next   = 1'b1;
                  case (r_state)
                     S_ADDR_ACK: begin
                        if (r_rd) begin
                           w_state_next = S_RD_BYTE;
                           w_tx_next    = r_snap[15:8];
                           w_sda_o_next = r_snap[15];
                           w_rd_lo_next = 1'b0;
                        end else begin
                           w_state_next = S_CMD;
                        end
                     end
                     S_CMD_ACK: w_state_next = (r_gc || r_cmd_rd) ? S_WAIT_STOP : S_DHI;
                     S_DHI_ACK: w_state_next = S_DLO;
                     default:   w_state_next = S_DHI;
                  endcase
               end
            end
            S_RD_BYTE: begin
               if (w_scl_rise && r_bit_cnt < 4'd8) begin
                  w_bit_cnt_next = r_bit_cnt + 4'd1;
               end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                  w_state_next = S_RD_ACK;
                  w_sda_o_next = 1'b1;
               end else if (w_scl_fall && r_bit_cnt != 4'd0) begin
                  w_tx_next    = {r_tx[6:0], 1'b0};
                  w_sda_o_next = r_tx[6];
               end
            end
            S_RD_ACK: begin
               if (w_scl_rise && r_bit_cnt == 4'd8) begin
                  if (w_sda) w_state_next = S_WAIT_STOP;
                  else       w_bit_cnt_next = 4'd9;
               end else if (w_scl_fall && r_bit_cnt == 4'd9) begin
                  w_state_next   = S_RD_BYTE;
                  w_bit_cnt_next = '0;
                  w_rd_lo_next   = ~r_rd_lo;
                  w_tx_next      = w_rd_byte;
                  w_sda_o_next   = w_rd_byte[7];
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign sda_o     = r_sda_o;
   assign ch0_value = r_ch0;
   assign ch1_value = r_ch1;
   assign update    = r_update;
   assign update_ch = r_update_ch;
   assign busy      = r_busy;

endmodule

// File: tb/tb_dac_i2c_target.sv
// Directed bench for dac_i2c_target: bit-banged I2C master on a wired-AND SDA bus.
module tb_dac_i2c_target;

   localparam int Q = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        scl_m;
   logic        sda_m;
   logic        glitch;
   logic        sda_bus;
   logic        scl_i;
   logic        sda_i;
   logic        sda_o;
   logic [15:0] ch0_value;
   logic [15:0] ch1_value;
   logic        update;
   logic        update_ch;
   logic        busy;

   int checks = 0;
   int failures = 0;
   int upd_cycles = 0;
   logic last_ch = 1'b0;

   assign sda_bus = sda_m & sda_o;
   assign sda_i   = sda_bus ^ glitch;
   assign scl_i   = scl_m;

   always #5 clk = ~clk;

   dac_i2c_target #(.TARGET_ADDR(7'h60), .FILTER_LEN(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .sda_o     (sda_o),
      .ch0_value (ch0_value),
      .ch1_value (ch1_value),
      .update    (update),
      .update_ch (update_ch),
      .busy      (busy)
   );

   always @(posedge clk) begin
      if (update === 1'b1) begin
         upd_cycles <= upd_cycles + 1;
         last_ch    <= update_ch;
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      wait_clk(Q);
      scl_m = 1'b1;
      wait_clk(2 * Q);
      sda_m = 1'b0;
      wait_clk(2 * Q);
      scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_clk(Q);
      sda_m = 1'b0;
      wait_clk(Q);
      scl_m = 1'b1;
      wait_clk(2 * Q);
      sda_m = 1'b1;
      wait_clk(4 * Q);
   endtask

   task automatic write_byte(input logic [7:0] b, input bit gl, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         wait_clk(Q);
         sda_m = b[i];
         wait_clk(Q);
         scl_m = 1'b1;
         if (gl) begin
            wait_clk(Q);
            glitch = 1'b1;
            wait_clk(1);
            glitch = 1'b0;
            wait_clk(Q - 1);
         end else begin
            wait_clk(2 * Q);
         end
         scl_m = 1'b0;
      end
      wait_clk(Q);
      sda_m = 1'b1;
      wait_clk(Q);
      scl_m = 1'b1;
      wait_clk(Q);
      ack = sda_bus;
      wait_clk(Q);
      scl_m = 1'b0;
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      sda_m = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         wait_clk(2 * Q);
         scl_m = 1'b1;
         wait_clk(Q);
         d[i] = sda_bus;
         wait_clk(Q);
         scl_m = 1'b0;
      end
      wait_clk(Q);
      sda_m = mack;
      wait_clk(Q);
      scl_m = 1'b1;
      wait_clk(2 * Q);
      scl_m = 1'b0;
      wait_clk(Q);
      sda_m = 1'b1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      scl_m  = 1'b1;
      sda_m  = 1'b1;
      glitch = 1'b0;
      wait_clk(5);
      rst_n = 1'b1;
      wait_clk(10);
      checks += 7;
      if (sda_o !== 1'b1) begin failures++; $display("FAIL rst_sda got=%b exp=1", sda_o); end
      if (ch0_value !== 16'h0) begin failures++; $display("FAIL rst_ch0 got=%h exp=0000", ch0_value); end
      if (ch1_value !== 16'h0) begin failures++; $display("FAIL rst_ch1 got=%h exp=0000", ch1_value); end
      if (update !== 1'b0) begin failures++; $display("FAIL rst_update got=%b exp=0", update); end
      if (update_ch !== 1'b0) begin failures++; $display("FAIL rst_update_ch got=%b exp=0", update_ch); end
      if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      if (upd_cycles !== 0) begin failures++; $display("FAIL rst_upd got=%0d exp=0", upd_cycles); end
      $display("txn reset released");
   endtask

   task automatic test_write_reg1();
      logic [3:0] acks;
      logic       mid_busy;
      int         base;
      base = upd_cycles;
      i2c_start();
      write_byte(8'hC0, 1'b0, acks[3]);
      write_byte(8'h08, 1'b0, acks[2]);
      mid_busy = busy;
      write_byte(8'hAB, 1'b0, acks[1]);
      write_byte(8'hCD, 1'b0, acks[0]);
      i2c_stop();
      checks += 7;
      if (acks !== 4'b0000) begin failures++; $display("FAIL wr1_acks got=%b exp=0000", acks); end
      if (mid_busy !== 1'b1) begin failures++; $display("FAIL wr1_busy_mid got=%b exp=1", mid_busy); end
      if (busy !== 1'b0) begin failures++; $display("FAIL wr1_busy_end got=%b exp=0", busy); end
      if (ch1_value !== 16'hABCD) begin failures++; $display("FAIL wr1_ch1 got=%h exp=abcd", ch1_value); end
      if (ch0_value !== 16'h0000) begin failures++; $display("FAIL wr1_ch0 got=%h exp=0000", ch0_value); end
      if (upd_cycles - base !== 1) begin failures++; $display("FAIL wr1_upd got=%0d exp=1", upd_cycles - base); end
      if (last_ch !== 1'b1) begin failures++; $display("FAIL wr1_upd_ch got=%b exp=1", last_ch); end
      $display("txn write 60/W cmd 08 data abcd acks=%b ch1=%h", acks, ch1_value);
   endtask

   task automatic test_addr_mismatch();
      logic [3:0] acks;
      logic       mid_busy;
      int         base;
      base = upd_cycles;
      i2c_start();
      write_byte(8'hC2, 1'b0, acks[3]);
      mid_busy = busy;
      write_byte(8'h08, 1'b0, acks[2]);
      write_byte(8'h11, 1'b0, acks[1]);
      write_byte(8'h22, 1'b0, acks[0]);
      i2c_stop();
      checks += 5;
      if (acks !== 4'b1111) begin failures++; $display("FAIL mis_acks got=%b exp=1111", acks); end
      if (mid_busy !== 1'b0) begin failures++; $display("FAIL mis_busy got=%b exp=0", mid_busy); end
      if (ch1_value !== 16'hABCD) begin failures++; $display("FAIL mis_ch1 got=%h exp=abcd", ch1_value); end
      if (upd_cycles - base !== 0) begin failures++; $display("FAIL mis_upd got=%0d exp=0", upd_cycles - base); end
      if (sda_o !== 1'b1) begin failures++; $display("FAIL mis_sda got=%b exp=1", sda_o); end
      $display("txn write 61/W acks=%b", acks);
   endtask

   task automatic test_readback();
      logic [3:0] wacks;
      logic [2:0] racks;
      logic [7:0] d0;
      logic [7:0] d1;
      logic       mid_busy;
      logic       sda_after;
      int         base;
      base = upd_cycles;
      i2c_start();
      write_byte(8'hC0, 1'b0, wacks[3]);
      write_byte(8'h00, 1'b0, wacks[2]);
      write_byte(8'h12, 1'b0, wacks[1]);
      write_byte(8'h34, 1'b0, wacks[0]);
      i2c_stop();
      $display("txn write reg0 1234 acks=%b", wacks);
      i2c_start();
      write_byte(8'hC0, 1'b0, racks[2]);
      write_byte(8'h06, 1'b0, racks[1]);
      i2c_start();
      write_byte(8'hC1, 1'b0, racks[0]);
      mid_busy = busy;
      read_byte(1'b0, d0);
      read_byte(1'b1, d1);
      wait_clk(Q);
      sda_after = sda_o;
      i2c_stop();
      checks += 8;
      if (wacks !== 4'b0000) begin failures++; $display("FAIL rb_wacks got=%b exp=0000", wacks); end
      if (ch0_value !== 16'h1234) begin failures++; $display("FAIL rb_ch0 got=%h exp=1234", ch0_value); end
      if (last_ch !== 1'b0) begin failures++; $display("FAIL rb_upd_ch got=%b exp=0", last_ch); end
      if (racks !== 3'b000) begin failures++; $display("FAIL rb_racks got=%b exp=000", racks); end
      if (mid_busy !== 1'b1) begin failures++; $display("FAIL rb_busy got=%b exp=1", mid_busy); end
      if (d0 !== 8'h12) begin failures++; $display("FAIL rb_hi got=%h exp=12", d0); end
      if (d1 !== 8'h34) begin failures++; $display("FAIL rb_lo got=%h exp=34", d1); end
      if (sda_after !== 1'b1) begin failures++; $display("FAIL rb_release got=%b exp=1", sda_after); end
      $display("txn read reg0 got=%h%h upd=%0d", d0, d1, upd_cycles - base);
   endtask

   task automatic test_bad_reg();
      logic [1:0] acks;
      int         base;
      base = upd_cycles;
      i2c_start();
      write_byte(8'hC0, 1'b0, acks[1]);
      write_byte(8'h10, 1'b0, acks[0]);
      i2c_stop();
      checks += 4;
      if (acks !== 2'b01) begin failures++; $display("FAIL bad_acks got=%b exp=01", acks); end
      if (ch0_value !== 16'h1234) begin failures++; $display("FAIL bad_ch0 got=%h exp=1234", ch0_value); end
      if (ch1_value !== 16'hABCD) begin failures++; $display("FAIL bad_ch1 got=%h exp=abcd", ch1_value); end
      if (upd_cycles - base !== 0) begin failures++; $display("FAIL bad_upd got=%0d exp=0", upd_cycles - base); end
      $display("txn write cmd 10 acks=%b", acks);
   endtask

   task automatic test_back_to_back();
      logic [5:0] acks;
      int         base;
      base = upd_cycles;
      i2c_start();
      write_byte(8'hC0, 1'b0, acks[5]);
      write_byte(8'h08, 1'b0, acks[4]);
      write_byte(8'h11, 1'b0, acks[3]);
      write_byte(8'h22, 1'b0, acks[2]);
      write_byte(8'h33, 1'b0, acks[1]);
      write_byte(8'h44, 1'b0, acks[0]);
      i2c_stop();
      checks += 4;
      if (acks !== 6'b000000) begin failures++; $display("FAIL b2b_acks got=%b exp=000000", acks); end
      if (ch1_value !== 16'h3344) begin failures++; $display("FAIL b2b_ch1 got=%h exp=3344", ch1_value); end
      if (ch0_value !== 16'h1234) begin failures++; $display("FAIL b2b_ch0 got=%h exp=1234", ch0_value); end
      if (upd_cycles - base !== 2) begin failures++; $display("FAIL b2b_upd got=%0d exp=2", upd_cycles - base); end
      $display("txn write reg1 pairs 1122 3344 acks=%b", acks);
   endtask

   task automatic test_partial_and_reset();
      logic [2:0] acks;
      logic       rack;
      int         base;
      base = upd_cycles;
      i2c_start();
      write_byte(8'hC0, 1'b0, acks[2]);
      write_byte(8'h00, 1'b0, acks[1]);
      write_byte(8'h55, 1'b0, acks[0]);
      i2c_stop();
      checks += 3;
      if (acks !== 3'b000) begin failures++; $display("FAIL part_acks got=%b exp=000", acks); end
      if (ch0_value !== 16'h1234) begin failures++; $display("FAIL part_ch0 got=%h exp=1234", ch0_value); end
      if (upd_cycles - base !== 0) begin failures++; $display("FAIL part_upd got=%0d exp=0", upd_cycles - base); end
      $display("txn partial write reg0 hi=55 acks=%b", acks);

      // Start a read of reg0 so the target is actively pulling SDA low for bit 7 of 0x12.
      i2c_start();
      write_byte(8'hC1, 1'b0, rack);
      wait_clk(Q + 2);
      checks += 3;
      if (rack !== 1'b0) begin failures++; $display("FAIL rst_mid_ack got=%b exp=0", rack); end
      if (sda_o !== 1'b0) begin failures++; $display("FAIL rst_mid_pre_sda got=%b exp=0", sda_o); end
      if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_pre_busy got=%b exp=1", busy); end
      rst_n = 1'b0;
      #1;
      checks += 6;
      if (sda_o !== 1'b1) begin failures++; $display("FAIL rst_mid_sda got=%b exp=1", sda_o); end
      if (ch0_value !== 16'h0) begin failures++; $display("FAIL rst_mid_ch0 got=%h exp=0000", ch0_value); end
      if (ch1_value !== 16'h0) begin failures++; $display("FAIL rst_mid_ch1 got=%h exp=0000", ch1_value); end
      if (update !== 1'b0) begin failures++; $display("FAIL rst_mid_update got=%b exp=0", update); end
      if (update_ch !== 1'b0) begin failures++; $display("FAIL rst_mid_update_ch got=%b exp=0", update_ch); end
      if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
      wait_clk(4);
      rst_n = 1'b1;
      sda_m = 1'b1;
      wait_clk(Q);
      scl_m = 1'b1;
      wait_clk(4 * Q);
      $display("txn reset asserted mid read byte");
   endtask

   task automatic test_glitch();
      logic [3:0] acks;
      int         base;
      base = upd_cycles;
      i2c_start();
      write_byte(8'hC0, 1'b1, acks[3]);
      write_byte(8'h08, 1'b1, acks[2]);
      write_byte(8'h5A, 1'b1, acks[1]);
      write_byte(8'hA5, 1'b1, acks[0]);
      i2c_stop();
      checks += 5;
      if (acks !== 4'b0000) begin failures++; $display("FAIL gl_acks got=%b exp=0000", acks); end
      if (ch1_value !== 16'h5AA5) begin failures++; $display("FAIL gl_ch1 got=%h exp=5aa5", ch1_value); end
      if (ch0_value !== 16'h0000) begin failures++; $display("FAIL gl_ch0 got=%h exp=0000", ch0_value); end
      if (upd_cycles - base !== 1) begin failures++; $display("FAIL gl_upd got=%0d exp=1", upd_cycles - base); end
      if (last_ch !== 1'b1) begin failures++; $display("FAIL gl_upd_ch got=%b exp=1", last_ch); end
      $display("txn glitched write reg1 5aa5 acks=%b", acks);
   endtask

   initial begin
      test_reset();
      test_write_reg1();
      test_addr_mismatch();
      test_readback();
      test_bad_reg();
      test_back_to_back();
      test_partial_and_reset();
      test_glitch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
